// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational 8-bit alu between NUM_REQ requesters.
// One transaction in flight: IDLE (grant) -> ISSUE (alu result sampled) -> RESP (held until taken).
// Illegal opcodes and divide-by-zero are screened here so the alu result is ignored for them.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_op,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [7:0]             resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic [3:0]             alu_op,
  output logic [7:0]             alu_operand1,
  output logic [7:0]             alu_operand2,
  input  logic [7:0]             alu_out
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [OP_W-1:0] OP_DIVU    = 4'd3;
  localparam logic [OP_W-1:0] OP_MOD     = 4'd4;
  localparam logic [OP_W-1:0] OP_DIV     = 4'd12;
  localparam logic [OP_W-1:0] OP_LEGAL_MAX = 4'd12;

  localparam logic [DATA_W-1:0] DATA_ILLEGAL = 8'h00;
  localparam logic [DATA_W-1:0] DATA_DIVZERO = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_busy;
  logic                r_resp_valid;
  logic [ID_W-1:0]     r_resp_id;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_err;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_alu_operand1;
  logic [DATA_W-1:0]   r_alu_operand2;

  logic                w_found;
  logic [ID_W-1:0]     w_grant;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic [OP_W-1:0]     w_op;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_data;
  logic                w_err;
  int unsigned         w_dist;
  int unsigned         w_best;

  // Round-robin pick: the valid requester closest at or after rr_ptr (modulo NUM_REQ) wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_dist  = 0;
    w_best  = NUM_REQ;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 32'(r_rr_ptr)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_found = 1'b1;
        w_grant = ID_W'(i);
      end
    end
  end

  // Select the winner's payload and form its one-hot accept strobe.
  always_comb begin
    w_op        = '0;
    w_a         = '0;
    w_b         = '0;
    w_req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_grant == ID_W'(i))) begin
        w_op           = req_op[4*i +: 4];
        w_a            = req_a[8*i +: 8];
        w_b            = req_b[8*i +: 8];
        w_req_ready[i] = 1'b1;
      end
    end
  end

  // Pointer moves one past the winner so the winner has lowest priority next time.
  always_comb begin
    w_ptr_nxt = ID_W'((32'(w_grant) + 32'd1) % NUM_REQ);
  end

  // Screen the issued operation; the alu output is only trusted for legal, non-zero-divisor ops.
  always_comb begin
    w_data = alu_out;
    w_err  = 1'b0;
    if (r_alu_op > OP_LEGAL_MAX) begin
      w_data = DATA_ILLEGAL;
      w_err  = 1'b1;
    end else if (((r_alu_op == OP_DIVU) || (r_alu_op == OP_MOD) || (r_alu_op == OP_DIV)) &&
                 (r_alu_operand2 == '0)) begin
      w_data = DATA_DIVZERO;
      w_err  = 1'b1;
    end
  end

  // Transaction FSM with all registered outputs; operand registers keep the last issued values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_data    <= '0;
      r_resp_err     <= 1'b0;
      r_alu_op       <= '0;
      r_alu_operand1 <= '0;
      r_alu_operand2 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_alu_op       <= w_op;
            r_alu_operand1 <= w_a;
            r_alu_operand2 <= w_b;
            r_resp_id      <= w_grant;
            r_rr_ptr       <= w_ptr_nxt;
            r_busy         <= 1'b1;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_resp_data  <= w_data;
          r_resp_err   <= w_err;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Accept strobe exists only while idle; everything else comes straight from registers.
  assign req_ready    = (r_state == ST_IDLE) ? w_req_ready : '0;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_data    = r_resp_data;
  assign resp_err     = r_resp_err;
  assign busy         = r_busy;
  assign alu_op       = r_alu_op;
  assign alu_operand1 = r_alu_operand1;
  assign alu_operand2 = r_alu_operand2;

endmodule
